// File: rtl/gf233_reduce_seq_if.sv
// Valid/ready bundle between the multiplier, the GF(2^233) reducer and its consumer.
// The master drives products in and results away; the slave is the reducer.
interface gf233_reduce_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [464:0] in_prod;
    logic         out_valid;
    logic         out_ready;
    logic [232:0] out_res;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/gf233_reduce_seq.sv
// Digit-serial reduction of a 465-bit GF(2)[x] product modulo x^233 + x^74 + 1.
// Folds DIGIT high-order coefficients per cycle, working from bit 464 down to bit 233.
module gf233_reduce_seq #(
    parameter int unsigned DIGIT = 32
) (
    input  logic               clk,
    input  logic               rst,
    gf233_reduce_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StFold, StDone} state_e;

    state_e       state_q, state_d;
    logic [464:0] w_q, w_d;
    logic [8:0]   top_q, top_d;
    logic [232:0] res_q, res_d;

    int           win_lo_raw;
    int           win_lo;
    logic         last_win;
    logic [464:0] folded;

    // Fold targets i-159 always sit below the window because DIGIT <= 128,
    // so every window bit can be folded from w_q independently.
    always_comb begin
        win_lo_raw = int'(top_q) - int'(DIGIT) + 1;
        win_lo     = (win_lo_raw < 233) ? 233 : win_lo_raw;
        last_win   = (win_lo_raw <= 233);
        folded     = w_q;
        for (int i = 233; i < 465; i++) begin
            if (i >= win_lo && i <= int'(top_q) && w_q[i]) begin
                folded[i]       = 1'b0;
                folded[i - 233] = ~folded[i - 233];
                folded[i - 159] = ~folded[i - 159];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        top_d         = top_q;
        res_d         = res_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_d     = bus.in_prod;
                    top_d   = 9'd464;
                    state_d = StFold;
                end
            end
            StFold: begin
                w_d   = folded;
                top_d = top_q - 9'(DIGIT);
                if (last_win) begin
                    res_d   = folded[232:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.out_res = res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            w_q     <= '0;
            top_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            top_q   <= top_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_gf233_reduce_seq.sv
// Bench for gf233_reduce_seq: three instances (DIGIT 32, 1, 128) checked against
// polynomial long division of carry-less products.
module tb_gf233_reduce_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [464:0] in_prod [3];
    logic [232:0] out_res [3];

    int n_vec = 0;
    int n_bad = 0;

    function automatic int digit_of(input int g);
        return (g == 0) ? 32 : ((g == 1) ? 1 : 128);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gf233_reduce_seq_if bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.in_prod   = in_prod[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_res[g]    = bus.out_res;
        gf233_reduce_seq #(.DIGIT(digit_of(g))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Reference: schoolbook long division by f(x), highest degree first.
    function automatic logic [232:0] ref_mod(input logic [464:0] p);
        logic [464:0] f;
        logic [464:0] r;
        f = '0;
        f[233] = 1'b1;
        f[74]  = 1'b1;
        f[0]   = 1'b1;
        r = p;
        for (int i = 464; i >= 233; i--) begin
            if (r[i]) r = r ^ (f << (i - 233));
        end
        return r[232:0];
    endfunction

    function automatic logic [464:0] clmul(input logic [232:0] a, input logic [232:0] b);
        logic [464:0] r;
        r = '0;
        for (int i = 0; i < 233; i++) begin
            if (a[i]) r = r ^ (465'(b) << i);
        end
        return r;
    endfunction

    function automatic logic [232:0] rand233();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v[232:0];
    endfunction

    function automatic logic [464:0] rand465();
        logic [479:0] v;
        for (int k = 0; k < 15; k++) v[k*32 +: 32] = $urandom;
        return v[464:0];
    endfunction

    task automatic check(input string name, input logic [464:0] act, input logic [464:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present p, wait for the accept edge, return at the following negedge with in_valid low
    // and garbage on in_prod.
    task automatic start(input int d, input logic [464:0] p);
        int n;
        in_prod[d]  = p;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("accept_timeout", 465'(in_ready[d]), 465'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_prod[d]  = rand465();
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen high.
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (!out_valid[d] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop(input int d);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic run_one(input int d, input logic [464:0] p, input logic [232:0] exp,
                           input string name);
        int lat;
        int n_fold;
        n_fold = (232 + digit_of(d) - 1) / digit_of(d);
        start(d, p);
        wait_valid(d, lat);
        check({name, "_lat"}, 465'(lat), 465'(n_fold + 1));
        check({name, "_res"}, 465'(out_res[d]), 465'(exp));
        pop(d);
        check({name, "_idle"}, 465'({in_ready[d], out_valid[d]}), 465'(2'b10));
    endtask

    typedef struct {
        logic [464:0] prod;
        logic [232:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [232:0] e;
        logic [464:0] p2;
        int           lat;

        vecs[0].prod = 465'(1) << 233;
        vecs[0].exp  = (233'(1) << 74) | 233'(1);
        vecs[1].prod = 465'(1) << 464;
        vecs[1].exp  = (233'(1) << 231) | (233'(1) << 146) | (233'(1) << 72);
        vecs[2].prod = 465'h1ABC;
        vecs[2].exp  = 233'h1ABC;
        vecs[3].prod = 465'(1) << 306;
        vecs[3].exp  = (233'(1) << 147) | (233'(1) << 73);
        vecs[4].prod = '0;
        vecs[4].exp  = '0;
        vecs[5].prod = {232'b0, {233{1'b1}}};
        vecs[5].exp  = {233{1'b1}};

        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) in_prod[d] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_reset", d), 465'({in_ready[d], out_valid[d]}), 465'(2'b10));
            check($sformatf("d%0d_reset_res", d), 465'(out_res[d]), '0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 6; v++) begin
                run_one(d, vecs[v].prod, vecs[v].exp, $sformatf("d%0d_vec%0d", digit_of(d), v));
            end
            for (int r = 0; r < ((d == 0) ? 300 : ((d == 1) ? 30 : 150)); r++) begin
                p2 = clmul(rand233(), rand233());
                run_one(d, p2, ref_mod(p2), $sformatf("d%0d_rand%0d", digit_of(d), r));
            end
        end

        // Consumer stalls in DONE, then a new product arrives in the release cycle.
        start(0, vecs[1].prod);
        wait_valid(0, lat);
        check("stall_lat", 465'(lat), 465'(9));
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 465'({out_valid[0], in_ready[0]}), 465'(2'b10));
            check("stall_res", 465'(out_res[0]), 465'(vecs[1].exp));
            @(negedge clk);
        end
        p2 = clmul(rand233(), rand233());
        in_prod[0]   = p2;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("release_idle", 465'({in_ready[0], out_valid[0]}), 465'(2'b10));
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_prod[0]  = rand465();
        check("b2b_busy", 465'(in_ready[0]), 465'(0));
        wait_valid(0, lat);
        check("b2b_lat", 465'(lat), 465'(9));
        check("b2b_res", 465'(out_res[0]), 465'(ref_mod(p2)));
        pop(0);

        // Reset during the 4th FOLD cycle aborts the operation.
        start(0, vecs[0].prod);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 465'({in_ready[0], out_valid[0]}), 465'(2'b10));
        check("abort_res", 465'(out_res[0]), '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_quiet", 465'(out_valid[0]), 465'(0));
        end
        e = vecs[0].exp;
        run_one(0, vecs[0].prod, e, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
